mem_port_rr_arbiter: RTL and testbench

//  Shares one memory request/response port among three requesters: imem (0), dmem (1) and debug (2).

---
 rtl/mem_port_arb_pkg.sv | 22 ++
 rtl/mem_port_arb_src_tracker.sv | 63 ++++++
 rtl/mem_port_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_rr_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared constants and helpers for the memory-port round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_port_arb_pkg;

    localparam int SRC_IMEM  = 0;
    localparam int SRC_DMEM  = 1;
    localparam int SRC_DBG   = 2;
    localparam int SRC_NBITS = 2;
    localparam int NUM_SRC   = 3;

    // Next requester in the cyclic order 0 -> 1 -> 2 -> 0
    function automatic logic [SRC_NBITS-1:0] rr_next(input logic [SRC_NBITS-1:0] src);
        return (src == SRC_NBITS'(SRC_DBG)) ? SRC_NBITS'(SRC_IMEM) : (src + 2'd1);
    endfunction

    // One-hot requester vector for a source index
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_NBITS-1:0] src);
        return 3'b001 << src;
    endfunction

endpackage

// File: rtl/mem_port_arb_src_tracker.sv
// In-order FIFO of source IDs for requests in flight on the shared memory port.
// Latency: head reflects a push one cycle later; full/empty are registered state.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
module mem_port_arb_src_tracker
    import mem_port_arb_pkg::*;
#(
    parameter int p_depth = 4
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [SRC_NBITS-1:0] push_src_i,
    input  logic                 pop_i,
    output logic [SRC_NBITS-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = PTR_W + 1;

    logic [SRC_NBITS-1:0] slot_q [p_depth];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(p_depth));
    assign empty_o = (count_q == '0);
    assign head_o  = slot_q[head_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth)
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_ok) tail_d = tail_q + 1'b1;
        if (pop_ok)  head_d = head_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset discards everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < p_depth; i++) slot_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_ok) slot_q[tail_q] <= push_src_i;
        end
    end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin share of one memory port among imem/dmem/debug, with in-order response routing.
// Latency: zero cycles on both request and response paths; nothing is buffered.
// Backpressure: stalls all requesters when the tracker is full or (MEM_PORT_ARB_DOMAIN_DRAIN_EN) a domain switch is draining.
module mem_port_rr_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 47,
    parameter int p_max_out    = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_domain,
    input  logic [3*p_req_nbits-1:0] in_req_msg,
    input  logic [2:0]               in_req_val,
    output logic [2:0]               in_req_rdy,
    output logic [p_resp_nbits-1:0]  in_resp_msg,
    output logic [2:0]               in_resp_val,
    input  logic [2:0]               in_resp_rdy,
    output logic [p_req_nbits-1:0]   mem_req_msg,
    output logic                     mem_req_val,
    input  logic                     mem_req_rdy,
    input  logic [p_resp_nbits-1:0]  mem_resp_msg,
    input  logic                     mem_resp_val,
    output logic                     mem_resp_rdy,
    output logic                     mem_domain,
    output logic                     err_stray
);

    logic [SRC_NBITS-1:0] rr_ptr_q, rr_ptr_d;
    logic                 err_stray_q, err_stray_d;
    logic [SRC_NBITS-1:0] ptr_p1, ptr_p2;
    logic [SRC_NBITS-1:0] grant_idx;
    logic [SRC_NBITS-1:0] head_src;
    logic                 any_val, can_issue, blocked;
    logic                 trk_full, trk_empty;
    logic                 req_fire, resp_fire, stray;

    assign ptr_p1  = rr_next(rr_ptr_q);
    assign ptr_p2  = rr_next(ptr_p1);
    assign any_val = |in_req_val;

    // Cyclic priority search: the valid requester closest at/after rr_ptr wins
    always_comb begin
        grant_idx = rr_ptr_q;
        if (in_req_val[ptr_p2])   grant_idx = ptr_p2;
        if (in_req_val[ptr_p1])   grant_idx = ptr_p1;
        if (in_req_val[rr_ptr_q]) grant_idx = rr_ptr_q;
    end

    // Steer the granted requester's message onto the shared port
    always_comb begin
        case (grant_idx)
            2'd0:    mem_req_msg = in_req_msg[0*p_req_nbits +: p_req_nbits];
            2'd1:    mem_req_msg = in_req_msg[1*p_req_nbits +: p_req_nbits];
            default: mem_req_msg = in_req_msg[2*p_req_nbits +: p_req_nbits];
        endcase
    end

    // Full is registered occupancy, so a same-cycle pop does not free a slot
    assign can_issue   = !trk_full && !blocked;
    assign mem_req_val = !reset && any_val && can_issue;
    assign in_req_rdy  = (!reset && any_val && can_issue && mem_req_rdy) ? src_onehot(grant_idx) : 3'b000;
    assign req_fire    = mem_req_val && mem_req_rdy;

    // Responses go to the oldest outstanding source; with nothing outstanding they are sunk
    assign in_resp_msg  = mem_resp_msg;
    assign in_resp_val  = (!reset && mem_resp_val && !trk_empty) ? src_onehot(head_src) : 3'b000;
    assign mem_resp_rdy = !reset && (trk_empty || in_resp_rdy[head_src]);
    assign resp_fire    = mem_resp_val && !trk_empty && in_resp_rdy[head_src];
    assign stray        = mem_resp_val && trk_empty;

    mem_port_arb_src_tracker #(
        .p_depth    (p_max_out)
    ) u_src_tracker (
        .clk        (clk),
        .reset      (reset),
        .push_i     (req_fire),
        .push_src_i (grant_idx),
        .pop_i      (resp_fire),
        .head_o     (head_src),
        .full_o     (trk_full),
        .empty_o    (trk_empty)
    );

    // Pointer advances past the winner only when a request actually fires
    always_comb begin
        rr_ptr_d    = req_fire ? rr_next(grant_idx) : rr_ptr_q;
        err_stray_d = err_stray_q || stray;
    end

    // Arbitration pointer and sticky stray-response flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= SRC_NBITS'(SRC_IMEM);
            err_stray_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign err_stray = err_stray_q;

`ifdef MEM_PORT_ARB_DOMAIN_DRAIN_EN
    logic cur_domain_q, cur_domain_d;

    // A domain change waits for all in-flight requests to return before adopting the new tag
    assign blocked      = (req_domain != cur_domain_q);
    assign cur_domain_d = (blocked && trk_empty) ? req_domain : cur_domain_q;
    assign mem_domain   = cur_domain_q;

    // Domain tag currently owning the shared port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_domain_q <= 1'b0;
        else       cur_domain_q <= cur_domain_d;
    end
`else
    assign blocked    = 1'b0;
    assign mem_domain = req_domain;
`endif

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
module tb_mem_port_rr_arbiter;

    localparam int RQ = 77;
    localparam int RS = 47;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_domain = 1'b0;
    logic [RQ-1:0]   req_m [3];
    logic [3*RQ-1:0] in_req_msg;
    logic [2:0]      in_req_val = 3'b000;
    logic [2:0]      in_req_rdy;
    logic [RS-1:0]   in_resp_msg;
    logic [2:0]      in_resp_val;
    logic [2:0]      in_resp_rdy = 3'b000;
    logic [RQ-1:0]   mem_req_msg;
    logic            mem_req_val;
    logic            mem_req_rdy = 1'b0;
    logic [RS-1:0]   mem_resp_msg = '0;
    logic            mem_resp_val = 1'b0;
    logic            mem_resp_rdy;
    logic            mem_domain;
    logic            err_stray;

    int n_cmp = 0;
    int n_bad = 0;

    assign in_req_msg = {req_m[2], req_m[1], req_m[0]};

    always #5 clk = ~clk;

    mem_port_rr_arbiter #(
        .p_req_nbits  (RQ),
        .p_resp_nbits (RS),
        .p_max_out    (MO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_domain   (req_domain),
        .in_req_msg   (in_req_msg),
        .in_req_val   (in_req_val),
        .in_req_rdy   (in_req_rdy),
        .in_resp_msg  (in_resp_msg),
        .in_resp_val  (in_resp_val),
        .in_resp_rdy  (in_resp_rdy),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy),
        .mem_domain   (mem_domain),
        .err_stray    (err_stray)
    );

    function automatic logic [RQ-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[RQ-1:0];
    endfunction

    function automatic logic [RS-1:0] rand_resp();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[RS-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_req_val   = 3'b000;
        in_resp_rdy  = 3'b000;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        req_domain   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) req_m[i] = rand_req();
        reset        = 1'b1;
        in_req_val   = 3'b111;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b111;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req_val got %b want 0", mem_req_val); end
        n_cmp++; if (in_req_rdy !== 3'b000) begin n_bad++; $display("FAIL rst_in_req_rdy got %b want 000", in_req_rdy); end
        n_cmp++; if (in_resp_val !== 3'b000) begin n_bad++; $display("FAIL rst_in_resp_val got %b want 000", in_resp_val); end
        n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_mem_resp_rdy got %b want 0", mem_resp_rdy); end
        n_cmp++; if (err_stray !== 1'b0) begin n_bad++; $display("FAIL rst_err_stray got %b want 0", err_stray); end
        next_cycle();
        mem_resp_val = 1'b0;
        reset        = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b1) begin n_bad++; $display("FAIL post_rst_req_val got %b want 1", mem_req_val); end
        n_cmp++; if (in_req_rdy !== 3'b001) begin n_bad++; $display("FAIL post_rst_imem_first got %b want 001", in_req_rdy); end
        n_cmp++; if (err_stray !== 1'b0) begin n_bad++; $display("FAIL post_rst_err_stray got %b want 0", err_stray); end
    endtask

    task automatic test_alternate();
        int g;
        do_reset();
        for (int i = 0; i < 3; i++) req_m[i] = rand_req();
        in_req_val  = 3'b011;
        mem_req_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            g = c % 2;
            @(negedge clk);
            n_cmp++; if (in_req_rdy !== 3'(1 << g)) begin n_bad++; $display("FAIL alt_grant c=%0d got %b want %b", c, in_req_rdy, 3'(1 << g)); end
            n_cmp++; if (mem_req_msg !== req_m[g]) begin n_bad++; $display("FAIL alt_msg c=%0d got %h want %h", c, mem_req_msg, req_m[g]); end
            next_cycle();
        end
    endtask

    task automatic test_all_three();
        int cnt [3];
        int g;
        do_reset();
        for (int i = 0; i < 3; i++) begin req_m[i] = rand_req(); cnt[i] = 0; end
        in_req_val  = 3'b111;
        mem_req_rdy = 1'b1;
        in_resp_rdy = 3'b111;
        for (int c = 0; c < 6; c++) begin
            mem_resp_val = (c >= 1);
            g = c % 3;
            @(negedge clk);
            for (int i = 0; i < 3; i++) cnt[i] += int'(in_req_rdy[i]);
            n_cmp++; if (in_req_rdy !== 3'(1 << g)) begin n_bad++; $display("FAIL rr3_grant c=%0d got %b want %b", c, in_req_rdy, 3'(1 << g)); end
            if (c >= 1) begin
                n_cmp++; if (in_resp_val !== 3'(1 << ((c - 1) % 3))) begin n_bad++; $display("FAIL rr3_resp_route c=%0d got %b want %b", c, in_resp_val, 3'(1 << ((c - 1) % 3))); end
            end
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cnt[i] != 2) begin n_bad++; $display("FAIL rr3_rdy_count req=%0d got %0d want 2", i, cnt[i]); end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_m[0]    = rand_req();
        in_req_val  = 3'b001;
        mem_req_rdy = 1'b1;
        for (int c = 0; c < MO; c++) begin
            @(negedge clk);
            n_cmp++; if (mem_req_val !== 1'b1) begin n_bad++; $display("FAIL fill_req_val c=%0d got %b want 1", c, mem_req_val); end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL full_stall_val got %b want 0", mem_req_val); end
        n_cmp++; if (in_req_rdy !== 3'b000) begin n_bad++; $display("FAIL full_stall_rdy got %b want 000", in_req_rdy); end
        next_cycle();
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b001;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL full_pop_same_cycle got %b want 0", mem_req_val); end
        n_cmp++; if (in_resp_val !== 3'b001) begin n_bad++; $display("FAIL full_pop_route got %b want 001", in_resp_val); end
        n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_bad++; $display("FAIL full_pop_rdy got %b want 1", mem_resp_rdy); end
        next_cycle();
        mem_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b1) begin n_bad++; $display("FAIL after_pop_issue got %b want 1", mem_req_val); end
        n_cmp++; if (in_req_rdy !== 3'b001) begin n_bad++; $display("FAIL after_pop_rdy got %b want 001", in_req_rdy); end
    endtask

    task automatic test_resp_route();
        logic [RS-1:0] d0, d1;
        do_reset();
        for (int i = 0; i < 3; i++) req_m[i] = rand_req();
        d0 = rand_resp();
        d1 = rand_resp();
        in_req_val  = 3'b010;
        mem_req_rdy = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_req_rdy !== 3'b010) begin n_bad++; $display("FAIL route_dmem_grant got %b want 010", in_req_rdy); end
        next_cycle();
        in_req_val = 3'b100;
        @(negedge clk);
        n_cmp++; if (in_req_rdy !== 3'b100) begin n_bad++; $display("FAIL route_dbg_grant got %b want 100", in_req_rdy); end
        next_cycle();
        in_req_val   = 3'b000;
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b111;
        mem_resp_msg = d0;
        @(negedge clk);
        n_cmp++; if (in_resp_val !== 3'b010) begin n_bad++; $display("FAIL route_resp0_val got %b want 010", in_resp_val); end
        n_cmp++; if (in_resp_msg !== d0) begin n_bad++; $display("FAIL route_resp0_msg got %h want %h", in_resp_msg, d0); end
        next_cycle();
        mem_resp_msg = d1;
        @(negedge clk);
        n_cmp++; if (in_resp_val !== 3'b100) begin n_bad++; $display("FAIL route_resp1_val got %b want 100", in_resp_val); end
        n_cmp++; if (in_resp_msg !== d1) begin n_bad++; $display("FAIL route_resp1_msg got %h want %h", in_resp_msg, d1); end
        next_cycle();
        mem_resp_val = 1'b0;
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        req_m[2]    = rand_req();
        in_req_val  = 3'b100;
        mem_req_rdy = 1'b1;
        next_cycle();
        in_req_val   = 3'b000;
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_hold_rdy c=%0d got %b want 0", c, mem_resp_rdy); end
            n_cmp++; if (in_resp_val !== 3'b100) begin n_bad++; $display("FAIL bp_hold_val c=%0d got %b want 100", c, in_resp_val); end
            next_cycle();
        end
        in_resp_rdy = 3'b100;
        @(negedge clk);
        n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_release_rdy got %b want 1", mem_resp_rdy); end
        next_cycle();
        mem_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (err_stray !== 1'b0) begin n_bad++; $display("FAIL bp_no_stray got %b want 0", err_stray); end
    endtask

    task automatic test_stray();
        do_reset();
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b000;
        @(negedge clk);
        n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_bad++; $display("FAIL stray_sink_rdy got %b want 1", mem_resp_rdy); end
        n_cmp++; if (in_resp_val !== 3'b000) begin n_bad++; $display("FAIL stray_no_val got %b want 000", in_resp_val); end
        next_cycle();
        mem_resp_val = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL stray_sticky got %b want 1", err_stray); end
        // Reset with a request in flight: its late response must count as stray
        do_reset();
        n_cmp++; if (err_stray !== 1'b0) begin n_bad++; $display("FAIL stray_cleared got %b want 0", err_stray); end
        req_m[1]    = rand_req();
        in_req_val  = 3'b010;
        mem_req_rdy = 1'b1;
        next_cycle();
        do_reset();
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b111;
        @(negedge clk);
        n_cmp++; if (in_resp_val !== 3'b000) begin n_bad++; $display("FAIL late_resp_val got %b want 000", in_resp_val); end
        next_cycle();
        mem_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (err_stray !== 1'b1) begin n_bad++; $display("FAIL late_resp_stray got %b want 1", err_stray); end
    endtask

    task automatic test_domain();
        do_reset();
        req_m[0]    = rand_req();
        mem_req_rdy = 1'b1;
`ifdef MEM_PORT_ARB_DOMAIN_DRAIN_EN
        in_req_val = 3'b001;
        repeat (2) next_cycle();
        req_domain = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL drain_block got %b want 0", mem_req_val); end
        n_cmp++; if (mem_domain !== 1'b0) begin n_bad++; $display("FAIL drain_old_domain got %b want 0", mem_domain); end
        next_cycle();
        mem_resp_val = 1'b1;
        in_resp_rdy  = 3'b111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL drain_pop_block c=%0d got %b want 0", c, mem_req_val); end
            next_cycle();
        end
        mem_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req_val !== 1'b0) begin n_bad++; $display("FAIL drain_switch_cycle got %b want 0", mem_req_val); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (mem_domain !== 1'b1) begin n_bad++; $display("FAIL drain_new_domain got %b want 1", mem_domain); end
        n_cmp++; if (mem_req_val !== 1'b1) begin n_bad++; $display("FAIL drain_resume got %b want 1", mem_req_val); end
`else
        in_req_val = 3'b001;
        req_domain = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_domain !== 1'b1) begin n_bad++; $display("FAIL dom_follow1 got %b want 1", mem_domain); end
        n_cmp++; if (mem_req_val !== 1'b1) begin n_bad++; $display("FAIL dom_no_block got %b want 1", mem_req_val); end
        next_cycle();
        req_domain = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_domain !== 1'b0) begin n_bad++; $display("FAIL dom_follow0 got %b want 0", mem_domain); end
`endif
    endtask

    // Reference: last-served requester, FIFO of outstanding sources, sticky error flag
    task automatic test_random();
        int         m_last;
        int         m_q [$];
        bit         m_err;
        bit         held [3];
        int         g;
        bit         e_req_val;
        logic [2:0] e_req_rdy, e_resp_val;
        logic       e_mem_resp_rdy;
        do_reset();
        m_last = 2;
        m_q.delete();
        m_err = 1'b0;
        for (int i = 0; i < 3; i++) held[i] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!held[i]) begin
                    in_req_val[i] = ($urandom_range(0, 2) != 0);
                    req_m[i]      = rand_req();
                end
            end
            mem_req_rdy  = ($urandom_range(0, 3) != 0);
            in_resp_rdy  = 3'($urandom_range(0, 7));
            mem_resp_msg = rand_resp();
            if (m_q.size() > 0) mem_resp_val = ($urandom_range(0, 2) != 0);
            else                mem_resp_val = ($urandom_range(0, 40) == 0);

            g = -1;
            for (int k = 1; k <= 3; k++) if (g < 0 && in_req_val[(m_last + k) % 3]) g = (m_last + k) % 3;
            e_req_val      = (g >= 0) && (m_q.size() < MO);
            e_req_rdy      = (e_req_val && mem_req_rdy) ? 3'(1 << g) : 3'b000;
            e_resp_val     = (mem_resp_val && m_q.size() > 0) ? 3'(1 << m_q[0]) : 3'b000;
            e_mem_resp_rdy = (m_q.size() > 0) ? in_resp_rdy[m_q[0]] : 1'b1;

            @(negedge clk);
            n_cmp++; if (mem_req_val !== e_req_val) begin n_bad++; $display("FAIL rnd_req_val c=%0d got %b want %b", c, mem_req_val, e_req_val); end
            n_cmp++; if (in_req_rdy !== e_req_rdy) begin n_bad++; $display("FAIL rnd_req_rdy c=%0d got %b want %b", c, in_req_rdy, e_req_rdy); end
            if (e_req_val) begin
                n_cmp++; if (mem_req_msg !== req_m[g]) begin n_bad++; $display("FAIL rnd_req_msg c=%0d got %h want %h", c, mem_req_msg, req_m[g]); end
            end
            n_cmp++; if (in_resp_val !== e_resp_val) begin n_bad++; $display("FAIL rnd_resp_val c=%0d got %b want %b", c, in_resp_val, e_resp_val); end
            n_cmp++; if (mem_resp_rdy !== e_mem_resp_rdy) begin n_bad++; $display("FAIL rnd_mem_resp_rdy c=%0d got %b want %b", c, mem_resp_rdy, e_mem_resp_rdy); end
            if (e_resp_val != 3'b000) begin
                n_cmp++; if (in_resp_msg !== mem_resp_msg) begin n_bad++; $display("FAIL rnd_resp_msg c=%0d got %h want %h", c, in_resp_msg, mem_resp_msg); end
            end
            n_cmp++; if (err_stray !== m_err) begin n_bad++; $display("FAIL rnd_err_stray c=%0d got %b want %b", c, err_stray, m_err); end
            n_cmp++; if (mem_domain !== 1'b0) begin n_bad++; $display("FAIL rnd_domain c=%0d got %b want 0", c, mem_domain); end

            if (mem_resp_val) begin
                if (m_q.size() == 0)          m_err = 1'b1;
                else if (in_resp_rdy[m_q[0]]) void'(m_q.pop_front());
            end
            if (e_req_val && mem_req_rdy) begin
                m_q.push_back(g);
                m_last = g;
            end
            for (int i = 0; i < 3; i++) held[i] = in_req_val[i] && !e_req_rdy[i];
            next_cycle();
        end
        mem_resp_val = 1'b0;
        in_req_val   = 3'b000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) req_m[i] = '0;
        test_reset();
        test_alternate();
        test_all_three();
        test_full_stall();
        test_resp_route();
        test_resp_backpressure();
        test_stray();
        test_domain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
